add_serial: RTL and testbench

ADD_SERIAL -- requirements
Module: add_serial

---
 rtl/add_pkg.sv | 18 +
 rtl/add_slice.sv | 27 ++
 rtl/add_serial.sv | 115 +++++++++++
 tb/tb_add_serial.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types for the digit-serial adder: FSM state encoding and counter sizing.
// Used by add_serial and add_slice.
package add_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes n digits, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational DIGIT-bit ripple-carry adder.
// add_serial evaluates one slice of the operands with it per cycle.
module add_slice
    import add_pkg::*;
#(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    always_comb begin
        logic [DIGIT:0] c;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(DIGIT); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[DIGIT];
    end

endmodule

// File: rtl/add_serial.sv
// Digit-serial adder: WIDTH-bit add, DIGIT bits per cycle, result valid on done.
// Define ADD_SERIAL_SUB_EN to add the sub port (a + ~b + 1, ci ignored).
module add_serial
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef ADD_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = cnt_width(N);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] b_in_c;
    logic             ci_in_c;
    logic [DIGIT-1:0] sum_c;
    logic             co_c;
    logic [WIDTH-1:0] s_next_c;
    logic             accept_c;
    logic             last_c;

    // Subtraction is folded into the captured operand and initial carry.
`ifdef ADD_SERIAL_SUB_EN
    assign b_in_c  = sub ? ~b : b;
    assign ci_in_c = sub ? 1'b1 : ci;
`else
    assign b_in_c  = b;
    assign ci_in_c = ci;
`endif

    assign accept_c = start && ((state == IDLE) || (state == DONE));
    assign last_c   = (cnt == CNT_W'(N - 1));

    add_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a (a_q[DIGIT-1:0]),
        .b (b_q[DIGIT-1:0]),
        .ci(carry_q),
        .s (sum_c),
        .co(co_c)
    );

    // Result slices enter at the MSB end so the first slice lands at the LSB after N shifts.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign s_next_c = sum_c;
        end else begin : g_multi
            assign s_next_c = {sum_c, s[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            co      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                state   <= RUN;
                a_q     <= a;
                b_q     <= b_in_c;
                carry_q <= ci_in_c;
                cnt     <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        a_q     <= a_q >> DIGIT;
                        b_q     <= b_q >> DIGIT;
                        carry_q <= co_c;
                        s       <= s_next_c;
                        cnt     <= cnt + CNT_W'(1);
                        if (last_c) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            co    <= co_c;
                        end
                    end
                    DONE:    state <= IDLE;
                    IDLE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_add_serial.sv
// Scoreboard bench for add_serial: driver pushes arithmetic expectations, monitor checks on done.
// Also checks a DIGIT=WIDTH instance for two-cycle latency.
module tb_add_serial;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIGIT = 4;
    localparam int unsigned N     = WIDTH / DIGIT;
`ifdef ADD_SERIAL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             start_w;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
`ifdef ADD_SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy, done, co;
    logic [WIDTH-1:0] s;
    logic             busy_w, done_w, co_w;
    logic [WIDTH-1:0] s_w;

    add_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci),
`ifdef ADD_SERIAL_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .s(s), .co(co)
    );

    add_serial #(.WIDTH(WIDTH), .DIGIT(WIDTH)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .a(a), .b(b), .ci(ci),
`ifdef ADD_SERIAL_SUB_EN
        .sub(sub),
`endif
        .busy(busy_w), .done(done_w), .s(s_w), .co(co_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        int               cyc;
    } exp_t;

    exp_t             q[$];
    int               n_vec    = 0;
    int               n_err    = 0;
    int               free_cyc = 0;
    int               run_lo   = 1;
    int               run_hi   = 0;
    logic [WIDTH-1:0] last_s   = '0;
    logic             last_co  = 1'b0;

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c, input logic sb);
        logic [WIDTH:0] r;
        if (sb) r = (WIDTH+1)'(x) + (WIDTH+1)'(~y) + (WIDTH+1)'(1);
        else    r = (WIDTH+1)'(x) + (WIDTH+1)'(y) + (WIDTH+1)'(c);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // One stimulus cycle; an accepted start books its result, busy window and done cycle.
    task automatic drive(input logic st, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic sv);
        @(negedge clk);
        #1;
        start = st;
        a     = av;
        b     = bv;
        ci    = cv;
`ifdef ADD_SERIAL_SUB_EN
        sub   = sv;
`endif
        if (st && rst_n && cyc >= free_cyc) begin
            logic [WIDTH:0] r;
            exp_t           e;
            r     = ref_sum(av, bv, cv, SUB_EN && sv);
            e.s   = r[WIDTH-1:0];
            e.co  = r[WIDTH];
            e.cyc = cyc + int'(N) + 1;
            q.push_back(e);
            run_lo   = cyc + 1;
            run_hi   = cyc + int'(N);
            free_cyc = cyc + int'(N) + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        start    = 1'b0;
        q.delete();
        run_lo   = 1;
        run_hi   = 0;
        free_cyc = 0;
        last_s   = '0;
        last_co  = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: busy window, result on done, missing done, and hold of s/co outside RUN.
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        exp_busy = (cyc >= run_lo) && (cyc <= run_hi);
        check("busy", 32'(busy), 32'(exp_busy));
        if (done) begin
            if (q.size() == 0) begin
                check("spurious_done", 32'(1), 32'(0));
            end else begin
                e = q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("sum", 32'(s), 32'(e.s));
                check("carry", 32'(co), 32'(e.co));
                last_s  = e.s;
                last_co = e.co;
            end
        end else if (q.size() != 0 && cyc >= q[0].cyc) begin
            check("missing_done", 32'(0), 32'(1));
            e = q.pop_front();
        end
        if (!done && !exp_busy) begin
            check("hold_s", 32'(s), 32'(last_s));
            check("hold_co", 32'(co), 32'(last_co));
        end
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        start_w = 1'b0;
        a       = '0;
        b       = '0;
        ci      = 1'b0;
`ifdef ADD_SERIAL_SUB_EN
        sub     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Basic add, then carry-out wrap cases
        drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0);
        idle(6);
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        idle(6);
        drive(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        idle(6);

        // Start pulsed during RUN is ignored
        drive(1'b1, 16'h1000, 16'h0100, 1'b0, 1'b0);
        drive(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0);
        drive(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        idle(6);

        // Reset at RUN cycle 2 aborts, then a fresh operation
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
        drive(1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
        do_reset(1);
        idle(1);
        drive(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
        idle(6);

        // Start held high: back-to-back operations every N+1 cycles
        for (int i = 0; i < 15; i++)
            drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
        idle(6);

`ifdef ADD_SERIAL_SUB_EN
        drive(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1);
        idle(6);
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(2);
            else drive($urandom_range(0, 2) == 0, WIDTH'($urandom), WIDTH'($urandom),
                       1'($urandom), 1'($urandom));
        end
        idle(8);

        // Single-slice instance: done two cycles after start
        @(negedge clk);
        #1;
        start   = 1'b0;
        a       = 16'hBEEF;
        b       = 16'h4321;
        ci      = 1'b1;
`ifdef ADD_SERIAL_SUB_EN
        sub     = 1'b0;
`endif
        start_w = 1'b1;
        @(negedge clk);
        #1;
        start_w = 1'b0;
        check("w_busy", 32'(busy_w), 32'(1));
        check("w_early_done", 32'(done_w), 32'(0));
        @(negedge clk);
        #1;
        check("w_done", 32'(done_w), 32'(1));
        check("w_sum", 32'(s_w), 32'h0211);
        check("w_carry", 32'(co_w), 32'(1));
        @(negedge clk);
        #1;
        check("w_done_pulse", 32'(done_w), 32'(0));
        check("w_idle", 32'(busy_w), 32'(0));

        check("drain", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
